clause_array: RTL and testbench

- Storage bin of NUM_CLAUSES_A_BIN clauses over NUM_VARS_A_BIN local variables, inside the SAT bin engine.
- Clause rows are loaded one by one from the bin base through one-hot write strobes.
- Combinationally, the block does unit propagation against the variable values driven by the base, and returns implied values.
- It also reports the first free row, which is where a learnt clause is inserted.

---
 rtl/clause_array_pkg.sv | 30 +++
 rtl/clause_row.sv | 74 +++++++
 rtl/clause_array.sv | 93 +++++++++
 tb/tb_clause_array.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clause_array_pkg.sv
// rtl/clause_array_pkg.sv - literal/value encodings and literal evaluation helper for clause_array
package clause_array_pkg;

  localparam int FIELD_W = 3;

  localparam logic [2:0] LIT_NONE = 3'd0;
  localparam logic [2:0] LIT_POS  = 3'd1;
  localparam logic [2:0] LIT_NEG  = 3'd2;

  localparam logic [1:0] VAL_FREE  = 2'b00;
  localparam logic [1:0] VAL_TRUE  = 2'b01;
  localparam logic [1:0] VAL_FALSE = 2'b10;

  typedef enum logic [1:0] {
    LS_ABSENT,
    LS_FALSE,
    LS_TRUE,
    LS_FREE
  } lit_state_e;

  // Codes 3..7 behave as an absent literal; value 2'b11 behaves as free.
  function automatic lit_state_e lit_state(input logic [2:0] lit, input logic [1:0] val);
    if (lit == LIT_NONE || lit > LIT_NEG) return LS_ABSENT;
    if (val == VAL_FREE) return LS_FREE;
    if (val == VAL_TRUE) return (lit == LIT_POS) ? LS_TRUE : LS_FALSE;
    if (val == VAL_FALSE) return (lit == LIT_POS) ? LS_FALSE : LS_TRUE;
    return LS_FREE;
  endfunction

endpackage

// File: rtl/clause_row.sv
// rtl/clause_row.sv - one clause row: storage, empty flag, unit detection (conflict under CLAUSE_ARRAY_CONFLICT_EN)
module clause_row
  import clause_array_pkg::*;
#(
  parameter int NUM_VARS = 8,
  parameter int LEN_W    = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_wr,
  input  logic [LEN_W-1:0]              i_len,
  input  logic [NUM_VARS*FIELD_W-1:0]   i_field,
  output logic                          o_empty,
  output logic [NUM_VARS-1:0]           o_unit_mask,
  output logic [1:0]                    o_unit_val
`ifdef CLAUSE_ARRAY_CONFLICT_EN
  ,
  output logic                          o_conflict
`endif
);

  logic [NUM_VARS*FIELD_W-1:0] r_lits;
  logic [LEN_W-1:0]            r_len;

  logic                        w_any_true;
  logic                        w_seen_free;
  logic                        w_multi_free;
  logic [NUM_VARS-1:0]         w_free_mask;
  logic [1:0]                  w_free_val;
  logic                        w_unit;
  lit_state_e                  w_state;

  // Row storage: reset clears the row, a strobe loads literals and length.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lits <= '0;
      r_len  <= '0;
    end else if (i_wr) begin
      r_lits <= i_field;
      r_len  <= i_len;
    end
  end

  // Evaluate every literal against the current values; track true/free literals.
  always_comb begin
    w_any_true   = 1'b0;
    w_seen_free  = 1'b0;
    w_multi_free = 1'b0;
    w_free_mask  = '0;
    w_free_val   = VAL_FREE;
    w_state      = LS_ABSENT;
    for (int v = 0; v < NUM_VARS; v++) begin
      w_state = lit_state(r_lits[v*FIELD_W +: FIELD_W], i_field[v*FIELD_W +: 2]);
      if (w_state == LS_TRUE) begin
        w_any_true = 1'b1;
      end else if (w_state == LS_FREE) begin
        if (w_seen_free) w_multi_free = 1'b1;
        w_seen_free    = 1'b1;
        w_free_mask[v] = 1'b1;
        w_free_val     = (r_lits[v*FIELD_W +: FIELD_W] == LIT_POS) ? VAL_TRUE : VAL_FALSE;
      end
    end
  end

  assign o_empty     = (r_len == '0);
  assign w_unit      = !o_empty && !w_any_true && w_seen_free && !w_multi_free;
  assign o_unit_mask = w_unit ? w_free_mask : '0;
  assign o_unit_val  = w_free_val;

`ifdef CLAUSE_ARRAY_CONFLICT_EN
  assign o_conflict  = !o_empty && !w_any_true && !w_seen_free;
`endif

endmodule

// File: rtl/clause_array.sv
// rtl/clause_array.sv - clause storage bin with unit propagation and first-free-row index (optional CLAUSE_ARRAY_CONFLICT_EN adds conflict_o)
module clause_array
  import clause_array_pkg::*;
#(
  parameter int NUM_CLAUSES_A_BIN = 8,
  parameter int NUM_VARS_A_BIN    = 8,
  parameter int WIDTH_VAR_STATES  = 30,
  parameter int WIDTH_C_LEN       = 5
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_CLAUSES_A_BIN-1:0]        wr_i,
  input  logic [WIDTH_C_LEN-1:0]              clause_len_i,
  input  logic [NUM_VARS_A_BIN*FIELD_W-1:0]   var_value_frombase_i,
  output logic [NUM_VARS_A_BIN*FIELD_W-1:0]   var_value_tobase_o,
  output logic [NUM_CLAUSES_A_BIN-1:0]        learntc_insert_index_o
`ifdef CLAUSE_ARRAY_CONFLICT_EN
  ,
  output logic                                conflict_o
`endif
);

  localparam int NC = NUM_CLAUSES_A_BIN;
  localparam int NV = NUM_VARS_A_BIN;

  // The base state word is only carried through; reject a degenerate configuration.
  if (WIDTH_VAR_STATES < 1) begin : g_bad_cfg
    $error("clause_array: WIDTH_VAR_STATES must be at least 1");
  end

  logic              w_prop_en;
  logic [NC-1:0]     w_empty;
  logic [NV-1:0]     w_unit_mask [NC];
  logic [1:0]        w_unit_val  [NC];
  logic [NC-1:0]     w_first_empty;
  logic [NV*FIELD_W-1:0] w_merged;
`ifdef CLAUSE_ARRAY_CONFLICT_EN
  logic [NC-1:0]     w_row_conflict;
`endif

  // Propagation results are meaningless while the shared bus carries a literal row.
  assign w_prop_en = (wr_i == '0);

  for (genvar g = 0; g < NC; g++) begin : g_row
    clause_row #(
      .NUM_VARS (NV),
      .LEN_W    (WIDTH_C_LEN)
    ) u_row (
      .clk         (clk),
      .rst         (rst),
      .i_wr        (wr_i[g]),
      .i_len       (clause_len_i),
      .i_field     (var_value_frombase_i),
      .o_empty     (w_empty[g]),
      .o_unit_mask (w_unit_mask[g]),
      .o_unit_val  (w_unit_val[g])
`ifdef CLAUSE_ARRAY_CONFLICT_EN
      ,
      .o_conflict  (w_row_conflict[g])
`endif
    );
  end

  // Priority encoder: one-hot of the lowest empty row, zero when full.
  always_comb begin
    w_first_empty = '0;
    for (int r = NC - 1; r >= 0; r--) begin
      if (w_empty[r]) begin
        w_first_empty    = '0;
        w_first_empty[r] = 1'b1;
      end
    end
  end

  // Merge: scanning rows high to low lets the lowest implying row win each variable.
  always_comb begin
    w_merged = '0;
    for (int v = 0; v < NV; v++) begin
      w_merged[v*FIELD_W +: FIELD_W] = {1'b0, var_value_frombase_i[v*FIELD_W +: 2]};
      for (int r = NC - 1; r >= 0; r--) begin
        if (w_unit_mask[r][v]) w_merged[v*FIELD_W +: FIELD_W] = {1'b1, w_unit_val[r]};
      end
    end
  end

  assign learntc_insert_index_o = w_first_empty;
  assign var_value_tobase_o     = w_prop_en ? w_merged : '0;

`ifdef CLAUSE_ARRAY_CONFLICT_EN
  assign conflict_o = w_prop_en && (|w_row_conflict);
`endif

endmodule

// File: tb/tb_clause_array.sv
// tb/tb_clause_array.sv - randomized self-checking bench for clause_array (conflict checks under CLAUSE_ARRAY_CONFLICT_EN)
module tb_clause_array;

  localparam int NC = 8;
  localparam int NV = 8;
  localparam int LW = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [NC-1:0]   wr_i;
  logic [LW-1:0]   clause_len_i;
  logic [NV*3-1:0] var_value_frombase_i;
  logic [NV*3-1:0] var_value_tobase_o;
  logic [NC-1:0]   learntc_insert_index_o;
`ifdef CLAUSE_ARRAY_CONFLICT_EN
  logic            conflict_o;
`endif

  always #5 clk = ~clk;

  clause_array #(
    .NUM_CLAUSES_A_BIN (NC),
    .NUM_VARS_A_BIN    (NV),
    .WIDTH_VAR_STATES  (30),
    .WIDTH_C_LEN       (LW)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .wr_i                   (wr_i),
    .clause_len_i           (clause_len_i),
    .var_value_frombase_i   (var_value_frombase_i),
    .var_value_tobase_o     (var_value_tobase_o),
    .learntc_insert_index_o (learntc_insert_index_o)
`ifdef CLAUSE_ARRAY_CONFLICT_EN
    ,
    .conflict_o             (conflict_o)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference contents: literal code per (row, variable) and stored length.
  int m_lit [NC][NV];
  int m_len [NC];

  function automatic void model_clear();
    for (int r = 0; r < NC; r++) begin
      m_len[r] = 0;
      for (int v = 0; v < NV; v++) m_lit[r][v] = 0;
    end
  endfunction

  function automatic logic [NC-1:0] exp_index();
    logic [NC-1:0] idx = '0;
    for (int r = 0; r < NC; r++)
      if (m_len[r] == 0) begin
        idx[r] = 1'b1;
        return idx;
      end
    return idx;
  endfunction

  // Truth of a literal: +1 true, -1 false, 0 free; absent literals never reach here.
  function automatic int lit_truth(input int lit, input int val);
    if (val == 0 || val == 3) return 0;
    if ((lit == 1) == (val == 1)) return 1;
    return -1;
  endfunction

  function automatic logic [NV*3-1:0] exp_out(input logic [NV*3-1:0] vals);
    logic [NV*3-1:0] o;
    bit done [NV];
    for (int v = 0; v < NV; v++) begin
      o[3*v +: 3] = {1'b0, vals[3*v +: 2]};
      done[v] = 0;
    end
    for (int r = 0; r < NC; r++) begin
      int n_true = 0, n_free = 0, fv = 0, fl = 0;
      if (m_len[r] == 0) continue;
      for (int v = 0; v < NV; v++) begin
        int lit = m_lit[r][v];
        int t;
        if (lit != 1 && lit != 2) continue;
        t = lit_truth(lit, int'(vals[3*v +: 2]));
        if (t > 0) n_true++;
        else if (t == 0) begin n_free++; fv = v; fl = lit; end
      end
      if (n_true == 0 && n_free == 1 && !done[fv]) begin
        o[3*fv +: 3] = {1'b1, (fl == 1) ? 2'b01 : 2'b10};
        done[fv] = 1;
      end
    end
    return o;
  endfunction

  function automatic logic exp_conflict(input logic [NV*3-1:0] vals);
    for (int r = 0; r < NC; r++) begin
      int n_ok = 0;
      if (m_len[r] == 0) continue;
      for (int v = 0; v < NV; v++)
        if (m_lit[r][v] == 1 || m_lit[r][v] == 2)
          if (lit_truth(m_lit[r][v], int'(vals[3*v +: 2])) >= 0) n_ok++;
      if (n_ok == 0) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [NV*3-1:0] rand_lits();
    logic [NV*3-1:0] l = '0;
    for (int v = 0; v < NV; v++) begin
      int k = $urandom_range(0, 9);
      if (k < 5)      l[3*v +: 3] = 3'd0;
      else if (k < 7) l[3*v +: 3] = 3'd1;
      else if (k < 9) l[3*v +: 3] = 3'd2;
      else            l[3*v +: 3] = 3'($urandom_range(3, 7));
    end
    return l;
  endfunction

  task automatic write_rows(input logic [NC-1:0] mask, input logic [NV*3-1:0] lits, input int len);
    @(negedge clk);
    wr_i = mask;
    var_value_frombase_i = lits;
    clause_len_i = LW'(len);
    #1;
    check("tobase_zero_during_wr", var_value_tobase_o, '0);
    @(posedge clk);
    for (int r = 0; r < NC; r++)
      if (mask[r]) begin
        m_len[r] = len;
        for (int v = 0; v < NV; v++) m_lit[r][v] = int'(lits[3*v +: 3]);
      end
    @(negedge clk);
    wr_i = '0;
  endtask

  task automatic reset_with(input logic [NC-1:0] mask);
    @(negedge clk);
    rst = 1'b1;
    wr_i = mask;
    clause_len_i = LW'(3);
    var_value_frombase_i = rand_lits();
    @(posedge clk);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    wr_i = '0;
  endtask

  task automatic apply(input string tag, input logic [NV*3-1:0] vals);
    @(negedge clk);
    wr_i = '0;
    var_value_frombase_i = vals;
    #1;
    check({tag, "_out"}, var_value_tobase_o, exp_out(vals));
    check({tag, "_idx"}, learntc_insert_index_o, exp_index());
`ifdef CLAUSE_ARRAY_CONFLICT_EN
    check({tag, "_conflict"}, conflict_o, exp_conflict(vals));
`endif
  endtask

  function automatic logic [NV*3-1:0] lits3(input int a, input int la, input int b, input int lb,
                                             input int c, input int lc);
    logic [NV*3-1:0] l = '0;
    l[3*a +: 3] = 3'(la);
    l[3*b +: 3] = 3'(lb);
    if (c >= 0) l[3*c +: 3] = 3'(lc);
    return l;
  endfunction

  logic [NV*3-1:0] vals;

  initial begin
    rst = 1'b1;
    wr_i = '0;
    clause_len_i = '0;
    var_value_frombase_i = '0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_idx", learntc_insert_index_o, 8'b0000_0001);
    check("reset_out", var_value_tobase_o, '0);
`ifdef CLAUSE_ARRAY_CONFLICT_EN
    check("reset_conflict", conflict_o, 1'b0);
`endif

    // First load set: rows 0..4.
    write_rows(8'h01, lits3(0, 2, 2, 1, -1, 0), 2);
    write_rows(8'h02, lits3(1, 2, 3, 1, 5, 2), 3);
    write_rows(8'h04, lits3(0, 2, 3, 1, 4, 2), 3);
    write_rows(8'h08, lits3(0, 1, 1, 1, 4, 1), 3);
    write_rows(8'h10, lits3(1, 1, 2, 2, 4, 2), 3);
    @(negedge clk);
    #1;
    check("load5_idx", learntc_insert_index_o, 8'b0010_0000);

    vals = '0;
    vals[3*2 +: 3] = 3'b010;
    apply("x2_false", vals);
    @(negedge clk);
    #1;
    check("x2_false_fixed", var_value_tobase_o, 24'h000086);

    vals = '0;
    vals[3*0 +: 3] = 3'b001;
    vals[3*2 +: 3] = 3'b010;
    apply("x0t_x2f", vals);
`ifdef CLAUSE_ARRAY_CONFLICT_EN
    check("conflict_set", conflict_o, 1'b1);
`endif
    vals[3*0 +: 3] = 3'b010;
    apply("x0f_x2f", vals);
`ifdef CLAUSE_ARRAY_CONFLICT_EN
    check("conflict_clear", conflict_o, 1'b0);
`endif

    // Fill rows 5..7 so the bin is full.
    for (int r = 5; r < NC; r++) write_rows(NC'(1 << r), rand_lits(), $urandom_range(1, 4));
    @(negedge clk);
    #1;
    check("full_idx", learntc_insert_index_o, 8'h00);

    // Multi-hot strobe writes identical data to both rows.
    write_rows(8'h06, lits3(3, 1, 6, 2, -1, 0), 2);
    for (int i = 0; i < 20; i++) apply("multi_wr", 24'($urandom()));

    // Randomized mix of row writes and propagation queries.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        logic [NC-1:0] m = NC'(1 << $urandom_range(0, NC - 1));
        if ($urandom_range(0, 7) == 0) m[$urandom_range(0, NC - 1)] = 1'b1;
        write_rows(m, rand_lits(), $urandom_range(0, 4));
      end else begin
        apply("rand", 24'($urandom()));
      end
    end

    // Reset after a full load, then reset and strobe together.
    for (int r = 0; r < NC; r++) write_rows(NC'(1 << r), rand_lits(), $urandom_range(1, 4));
    reset_with('0);
    #1;
    check("rst_after_full_idx", learntc_insert_index_o, 8'b0000_0001);
    reset_with(8'h01);
    #1;
    check("rst_beats_wr_idx", learntc_insert_index_o, 8'b0000_0001);
    apply("after_rst", 24'($urandom()));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
